// File: rtl/gelato_types_pkg.sv
// Shared Gelato cache types plus the L2 refill arbiter state encoding.
package gelato_types;

   typedef logic [31:0]  addr_t;
   typedef logic [511:0] l1_cache_line_t;

   typedef enum logic [1:0] {L2A_IDLE, L2A_REQ, L2A_RESP} l2_arb_state_e;

endpackage

// File: rtl/gelato_rr_picker.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping at N.
module gelato_rr_picker #(
   parameter int unsigned N = 4,
   localparam int unsigned ID_W = $clog2(N)
) (
   input  logic [N-1:0]    req,
   input  logic [ID_W-1:0] ptr,
   output logic [ID_W-1:0] gnt_id,
   output logic            gnt_vld
);

   logic [N-1:0]  req_rot;
   logic [ID_W:0] sum;
   logic          found;

   always_comb begin
      // Bit i of the rotated vector is channel (ptr + i) mod N.
      req_rot = N'({req, req} >> ptr);
      found   = 1'b0;
      sum     = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (req_rot[i] && !found) begin
            found = 1'b1;
            sum   = {1'b0, ptr} + (ID_W+1)'(i);
         end
      end
      if (sum >= (ID_W+1)'(N)) begin
         sum = sum - (ID_W+1)'(N);
      end
      gnt_id  = sum[ID_W-1:0];
      gnt_vld = found;
   end

endmodule

// File: rtl/gelato_l2_req_arbiter.sv
// Round-robin L1->L2 line-refill arbiter, one L2 transaction at a time.
// Define GELATO_L2_ARB_MERGE_EN to also complete every waiting channel that asked for the same line.
module gelato_l2_req_arbiter
   import gelato_types::*;
#(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned ADDR_W = $bits(addr_t),
   parameter int unsigned LINE_W = $bits(l1_cache_line_t),
   localparam int unsigned ID_W = $clog2(NUM_CH)
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [NUM_CH-1:0]              ch_valid,
   input  logic [NUM_CH-1:0][ADDR_W-1:0]  ch_addr,
   output logic [NUM_CH-1:0]              ch_done,
   output logic [LINE_W-1:0]              ch_data,
   output logic                           l2_valid,
   output logic [ADDR_W-1:0]              l2_addr,
   input  logic                           l2_done,
   input  logic [LINE_W-1:0]              l2_data,
   output logic                           busy,
   output logic [ID_W-1:0]                grant_id
);

   l2_arb_state_e     state_q, state_d;
   logic [ID_W-1:0]   grant_id_q, grant_id_d;
   logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [NUM_CH-1:0] ch_done_q, ch_done_d;
   logic [LINE_W-1:0] ch_data_q, ch_data_d;
   logic [ADDR_W-1:0] l2_addr_q, l2_addr_d;
   logic              l2_valid_q, l2_valid_d;
   logic              busy_q, busy_d;
   logic [ID_W-1:0]   pick_id;
   logic              pick_vld;

   gelato_rr_picker #(.N(NUM_CH)) u_picker (
      .req     (ch_valid),
      .ptr     (rr_ptr_q),
      .gnt_id  (pick_id),
      .gnt_vld (pick_vld)
   );

   always_comb begin
      state_d    = state_q;
      grant_id_d = grant_id_q;
      rr_ptr_d   = rr_ptr_q;
      ch_done_d  = '0;
      ch_data_d  = ch_data_q;
      l2_addr_d  = l2_addr_q;
      l2_valid_d = l2_valid_q;
      busy_d     = busy_q;
      case (state_q)
         L2A_IDLE: begin
            if (pick_vld) begin
               state_d    = L2A_REQ;
               grant_id_d = pick_id;
               l2_addr_d  = ch_addr[pick_id];
               l2_valid_d = 1'b1;
               busy_d     = 1'b1;
            end
         end
         L2A_REQ: begin
            if (l2_done) begin
               state_d               = L2A_RESP;
               ch_data_d             = l2_data;
               l2_valid_d            = 1'b0;
               ch_done_d[grant_id_q] = 1'b1;
`ifdef GELATO_L2_ARB_MERGE_EN
               // Masters hold valid/addr until their done, so the match taken here equals the RESP-cycle view.
               for (int unsigned c = 0; c < NUM_CH; c++) begin
                  if (ch_valid[c] && (ch_addr[c] == l2_addr_q)) begin
                     ch_done_d[c] = 1'b1;
                  end
               end
`endif
            end
         end
         L2A_RESP: begin
            state_d    = L2A_IDLE;
            busy_d     = 1'b0;
            grant_id_d = '0;
            rr_ptr_d   = (grant_id_q == ID_W'(NUM_CH - 1)) ? '0 : grant_id_q + 1'b1;
         end
         default: begin
            state_d    = L2A_IDLE;
            l2_valid_d = 1'b0;
            busy_d     = 1'b0;
            grant_id_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= L2A_IDLE;
         grant_id_q <= '0;
         rr_ptr_q   <= '0;
         ch_done_q  <= '0;
         ch_data_q  <= '0;
         l2_addr_q  <= '0;
         l2_valid_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         grant_id_q <= grant_id_d;
         rr_ptr_q   <= rr_ptr_d;
         ch_done_q  <= ch_done_d;
         ch_data_q  <= ch_data_d;
         l2_addr_q  <= l2_addr_d;
         l2_valid_q <= l2_valid_d;
         busy_q     <= busy_d;
      end
   end

   assign ch_done  = ch_done_q;
   assign ch_data  = ch_data_q;
   assign l2_valid = l2_valid_q;
   assign l2_addr  = l2_addr_q;
   assign busy     = busy_q;
   assign grant_id = grant_id_q;

endmodule

// File: tb/tb_gelato_l2_req_arbiter.sv
// Self-checking bench for gelato_l2_req_arbiter: directed vectors plus randomized traffic against a transaction model.
module tb_gelato_l2_req_arbiter;

   localparam int N  = 4;
   localparam int AW = 32;
   localparam int LW = 512;

   logic                   clk = 1'b0;
   logic                   rst_n;
   logic [N-1:0]           ch_valid;
   logic [N-1:0][AW-1:0]   ch_addr;
   logic [N-1:0]           ch_done;
   logic [LW-1:0]          ch_data;
   logic                   l2_valid;
   logic [AW-1:0]          l2_addr;
   logic                   l2_done;
   logic [LW-1:0]          l2_data;
   logic                   busy;
   logic [1:0]             grant_id;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   int last_done_cyc = 0;
   logic [LW-1:0] last_line = '0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   gelato_l2_req_arbiter #(.NUM_CH(N), .ADDR_W(AW), .LINE_W(LW)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .ch_valid (ch_valid),
      .ch_addr  (ch_addr),
      .ch_done  (ch_done),
      .ch_data  (ch_data),
      .l2_valid (l2_valid),
      .l2_addr  (l2_addr),
      .l2_done  (l2_done),
      .l2_data  (l2_data),
      .busy     (busy),
      .grant_id (grant_id)
   );

   typedef struct {
      int           setup;
      logic [N-1:0] mask;
      int           exp_g;
   } vec_t;

   vec_t tbl[7];

   task automatic chkv(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic chkd(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [LW-1:0] rand_line();
      logic [LW-1:0] r;
      r = '0;
      for (int i = 0; i < LW / 32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   function automatic int pick(input logic [N-1:0] v, input int p);
      for (int i = 0; i < N; i++) begin
         int c;
         c = (p + i) % N;
         if (v[c]) return c;
      end
      return 0;
   endfunction

   task automatic do_reset();
      ch_valid = '0;
      l2_done  = 1'b0;
      rst_n    = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   // Starts in an IDLE cycle; ends in the IDLE cycle following RESP.
   task automatic serve(input string nm, input logic [N-1:0] raise, input int exp_g,
                        input logic [AW-1:0] exp_a, input int dly, input logic [N-1:0] exp_done);
      logic [LW-1:0] line;
      ch_valid = ch_valid | raise;
      tick();
      chkv({nm, " l2_valid"}, 32'(l2_valid), 32'(1));
      chkv({nm, " busy"}, 32'(busy), 32'(1));
      chkv({nm, " grant_id"}, 32'(grant_id), 32'(exp_g));
      chkv({nm, " l2_addr"}, l2_addr, exp_a);
      for (int i = 1; i < dly; i++) begin
         tick();
         chkv({nm, " l2_valid hold"}, 32'(l2_valid), 32'(1));
         chkv({nm, " early ch_done"}, 32'(ch_done), 32'(0));
      end
      line    = rand_line();
      l2_done = 1'b1;
      l2_data = line;
      tick();
      l2_done = 1'b0;
      l2_data = rand_line();
      chkv({nm, " ch_done"}, 32'(ch_done), 32'(exp_done));
      chkd({nm, " ch_data"}, ch_data, line);
      chkv({nm, " l2_valid resp"}, 32'(l2_valid), 32'(0));
      last_done_cyc = cyc;
      last_line     = line;
      ch_valid      = ch_valid & ~ch_done;
      tick();
      chkv({nm, " done pulse end"}, 32'(ch_done), 32'(0));
      chkv({nm, " busy idle"}, 32'(busy), 32'(0));
      chkv({nm, " grant_id idle"}, 32'(grant_id), 32'(0));
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int prev_done;
      logic [LW-1:0] saved;
      logic [LW-1:0] line;

      rst_n    = 1'b0;
      ch_valid = '0;
      ch_addr  = '0;
      l2_done  = 1'b0;
      l2_data  = '0;
      #1;
      chkv("reset ch_done", 32'(ch_done), 32'(0));
      chkd("reset ch_data", ch_data, '0);
      chkv("reset l2_valid", 32'(l2_valid), 32'(0));
      chkv("reset l2_addr", l2_addr, 32'(0));
      chkv("reset busy", 32'(busy), 32'(0));
      chkv("reset grant_id", 32'(grant_id), 32'(0));
      tick();
      rst_n = 1'b1;
      tick();

      // single request with slow L2
      ch_addr[2] = 32'h1000;
      serve("t1", 4'b0100, 2, 32'h1000, 5, 4'b0100);

      // all channels busy: strict rotation, a completion every 3 cycles
      do_reset();
      for (int c = 0; c < N; c++) ch_addr[c] = 32'h5000 + 32'(c) * 32'h100;
      prev_done = 0;
      for (int i = 0; i < 6; i++) begin
         serve("t2", 4'b1111, i % N, 32'h5000 + 32'(i % N) * 32'h100, 1, 4'(1 << (i % N)));
         if (i > 0) chkv("t2 done spacing", 32'(last_done_cyc - prev_done), 32'(3));
         prev_done = last_done_cyc;
      end
      ch_valid = '0;

      // wrap scan from rr_ptr=3, then the pointer continues from 2
      ch_addr[2] = 32'hA000;
      serve("t3 setup", 4'b0100, 2, 32'hA000, 1, 4'b0100);
      ch_addr[1] = 32'hA100;
      serve("t3 wrap", 4'b0010, 1, 32'hA100, 1, 4'b0010);
      for (int c = 0; c < N; c++) ch_addr[c] = 32'hB000 + 32'(c) * 32'h40;
      serve("t3 next", 4'b1111, 2, 32'hB080, 1, 4'b0100);
      ch_valid = '0;

      tbl[0] = '{setup: 0, mask: 4'b1111, exp_g: 1};
      tbl[1] = '{setup: 0, mask: 4'b0001, exp_g: 0};
      tbl[2] = '{setup: 2, mask: 4'b0010, exp_g: 1};
      tbl[3] = '{setup: 3, mask: 4'b1100, exp_g: 2};
      tbl[4] = '{setup: 1, mask: 4'b0011, exp_g: 0};
      tbl[5] = '{setup: 2, mask: 4'b1001, exp_g: 3};
      tbl[6] = '{setup: 3, mask: 4'b1000, exp_g: 3};
      for (int r = 0; r < 7; r++) begin
         ch_addr[tbl[r].setup] = 32'h9000;
         serve("tbl setup", 4'(1 << tbl[r].setup), tbl[r].setup, 32'h9000, 1, 4'(1 << tbl[r].setup));
         for (int c = 0; c < N; c++) ch_addr[c] = 32'h4000 + 32'(c) * 32'h40;
         serve("tbl pick", tbl[r].mask, tbl[r].exp_g, 32'h4000 + 32'(tbl[r].exp_g) * 32'h40, 2,
               4'(1 << tbl[r].exp_g));
         ch_valid = '0;
      end

      // reset in the middle of an L2 transaction
      ch_addr[0] = 32'h6000;
      ch_valid   = 4'b0001;
      tick();
      tick();
      chkv("t4 l2_valid before reset", 32'(l2_valid), 32'(1));
      rst_n = 1'b0;
      #1;
      chkv("t4 l2_valid async drop", 32'(l2_valid), 32'(0));
      chkv("t4 busy async drop", 32'(busy), 32'(0));
      chkd("t4 ch_data cleared", ch_data, '0);
      ch_valid = '0;
      for (int i = 0; i < 2; i++) begin
         tick();
         chkv("t4 no ch_done", 32'(ch_done), 32'(0));
      end
      rst_n = 1'b1;
      tick();
      ch_addr[2] = 32'h6100;
      serve("t4 after", 4'b0100, 2, 32'h6100, 2, 4'b0100);

      // two channels want the same line
      do_reset();
      ch_addr[0] = 32'h2040;
      ch_addr[1] = 32'h3000;
      ch_addr[2] = 32'h2040;
`ifdef GELATO_L2_ARB_MERGE_EN
      serve("t5 merged", 4'b0111, 0, 32'h2040, 1, 4'b0101);
      serve("t5 ch1", 4'b0000, 1, 32'h3000, 1, 4'b0010);
`else
      serve("t5 ch0", 4'b0111, 0, 32'h2040, 1, 4'b0001);
      serve("t5 ch1", 4'b0000, 1, 32'h3000, 1, 4'b0010);
      serve("t5 ch2", 4'b0000, 2, 32'h2040, 1, 4'b0100);
`endif
      chkv("t5 all served", 32'(ch_valid), 32'(0));

      // stray l2_done while idle
      saved   = last_line;
      l2_done = 1'b1;
      l2_data = rand_line();
      tick();
      l2_done = 1'b0;
      chkv("t6 busy", 32'(busy), 32'(0));
      chkv("t6 l2_valid", 32'(l2_valid), 32'(0));
      chkv("t6 ch_done", 32'(ch_done), 32'(0));
      chkd("t6 ch_data held", ch_data, saved);
      tick();
      chkv("t6 ch_done later", 32'(ch_done), 32'(0));

      // requester withdraws and moves its address while granted
      ch_addr[3] = 32'h7000;
      ch_valid   = 4'b1000;
      tick();
      chkv("t7 grant", 32'(grant_id), 32'(3));
      ch_valid   = '0;
      ch_addr[3] = 32'h7777;
      tick();
      chkv("t7 l2_addr latched", l2_addr, 32'h7000);
      chkv("t7 l2_valid held", 32'(l2_valid), 32'(1));
      line    = rand_line();
      l2_done = 1'b1;
      l2_data = line;
      tick();
      l2_done = 1'b0;
      chkv("t7 ch_done", 32'(ch_done), 32'(4'b1000));
      chkd("t7 ch_data", ch_data, line);
      tick();
      chkv("t7 idle", 32'(busy), 32'(0));

      // randomized traffic against a transaction-level model
      do_reset();
      begin
         logic [AW-1:0] pool [4];
         logic [N-1:0]         pv;
         logic [N-1:0][AW-1:0] pa;
         logic                 pd;
         logic [LW-1:0]        pdata;
         int                   ph, mptr, mg;
         logic [AW-1:0]        maddr;
         logic [LW-1:0]        mdata;
         logic [N-1:0]         mmask;
         pool  = '{32'h1000, 32'h2040, 32'h3000, 32'h2040};
         ph    = 0;
         mptr  = 0;
         mg    = 0;
         maddr = '0;
         mdata = '0;
         mmask = '0;
         for (int t = 0; t < 2000; t++) begin
            for (int c = 0; c < N; c++) begin
               if (ch_done[c]) begin
                  ch_valid[c] = 1'b0;
               end else if (!ch_valid[c] && ($urandom % 3 == 0)) begin
                  ch_valid[c] = 1'b1;
                  ch_addr[c]  = pool[$urandom % 4];
               end
            end
            l2_done = (ph == 1) ? ($urandom % 3 == 0) : ($urandom % 10 == 0);
            l2_data = rand_line();
            pv = ch_valid;
            pa = ch_addr;
            pd = l2_done;
            pdata = l2_data;
            tick();
            if (ph == 0) begin
               if (pv != '0) begin
                  mg    = pick(pv, mptr);
                  maddr = pa[mg];
                  ph    = 1;
               end
            end else if (ph == 1) begin
               if (pd) begin
                  mdata     = pdata;
                  mmask     = '0;
                  mmask[mg] = 1'b1;
`ifdef GELATO_L2_ARB_MERGE_EN
                  for (int c = 0; c < N; c++) if (pv[c] && pa[c] == maddr) mmask[c] = 1'b1;
`endif
                  ph = 2;
               end
            end else begin
               mptr = (mg + 1) % N;
               ph   = 0;
            end
            chkv("rnd l2_valid", 32'(l2_valid), 32'(ph == 1));
            chkv("rnd busy", 32'(busy), 32'(ph != 0));
            chkv("rnd grant_id", 32'(grant_id), 32'((ph == 0) ? 0 : mg));
            chkv("rnd l2_addr", l2_addr, maddr);
            chkv("rnd ch_done", 32'(ch_done), 32'((ph == 2) ? mmask : 4'b0000));
            chkd("rnd ch_data", ch_data, mdata);
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
